// File: rtl/rename_register_file.sv
// Architectural register file with an in-order rename file for a dual-issue core.
// Renames two destinations, serves four operand reads, takes two writebacks and two retires per cycle.
module rename_register_file #(
  parameter int DATA_W = 32,
  parameter int ARF_N  = 32,
  parameter int RRF_N  = 8,
  parameter int TAG_W  = $clog2(RRF_N),
  parameter int AW     = $clog2(ARF_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              map_en_A,
  input  logic              map_en_B,
  input  logic [AW-1:0]     map_addr_A,
  input  logic [AW-1:0]     map_addr_B,
  output logic [TAG_W-1:0]  map_tag_A,
  output logic [TAG_W-1:0]  map_tag_B,
  output logic              map_stall,
  input  logic [AW-1:0]     rd_addr_A0,
  input  logic [AW-1:0]     rd_addr_A1,
  input  logic [AW-1:0]     rd_addr_B0,
  input  logic [AW-1:0]     rd_addr_B1,
  output logic [DATA_W-1:0] rd_data_A0,
  output logic [DATA_W-1:0] rd_data_A1,
  output logic [DATA_W-1:0] rd_data_B0,
  output logic [DATA_W-1:0] rd_data_B1,
  output logic              rd_ready_A0,
  output logic              rd_ready_A1,
  output logic              rd_ready_B0,
  output logic              rd_ready_B1,
  output logic [TAG_W-1:0]  rd_tag_A0,
  output logic [TAG_W-1:0]  rd_tag_A1,
  output logic [TAG_W-1:0]  rd_tag_B0,
  output logic [TAG_W-1:0]  rd_tag_B1,
  input  logic              wb_en_A,
  input  logic              wb_en_B,
  input  logic [TAG_W-1:0]  wb_tag_A,
  input  logic [TAG_W-1:0]  wb_tag_B,
  input  logic [DATA_W-1:0] wb_data_A,
  input  logic [DATA_W-1:0] wb_data_B,
  input  logic              cm_en_A,
  input  logic              cm_en_B,
  input  logic [TAG_W-1:0]  cm_tag_A,
  input  logic [TAG_W-1:0]  cm_tag_B,
  input  logic              flush,
  output logic [TAG_W:0]    free_count
);

  logic [DATA_W-1:0] arfVal     [ARF_N];
  logic [DATA_W-1:0] arfValNxt  [ARF_N];
  logic [TAG_W-1:0]  arfTag     [ARF_N];
  logic [TAG_W-1:0]  arfTagNxt  [ARF_N];
  logic [ARF_N-1:0]  arfBusy, arfBusyNxt;
  logic [DATA_W-1:0] rrfVal     [RRF_N];
  logic [DATA_W-1:0] rrfValNxt  [RRF_N];
  logic [AW-1:0]     rrfDest    [RRF_N];
  logic [AW-1:0]     rrfDestNxt [RRF_N];
  logic [RRF_N-1:0]  rrfBusy, rrfBusyNxt;
  logic [RRF_N-1:0]  rrfValid, rrfValidNxt;
  logic [TAG_W:0]    freeCount, freeNxt;

  logic [TAG_W-1:0]  firstTag, secondTag;
  logic              firstOk, secondOk;
  logic              reqA, reqB, grantA, grantB;
  logic [TAG_W:0]    reqCnt;

  logic [AW-1:0]     rdAddr  [4];
  logic [DATA_W-1:0] rdData  [4];
  logic              rdReady [4];
  logic [TAG_W-1:0]  rdTag   [4];

  // Lowest and second-lowest free rename entries
  always_comb begin
    firstTag  = '0;
    secondTag = '0;
    firstOk   = 1'b0;
    secondOk  = 1'b0;
    for (int i = 0; i < RRF_N; i++) begin
      if (!rrfBusy[i]) begin
        if (!firstOk) begin
          firstTag = TAG_W'(i);
          firstOk  = 1'b1;
        end else if (!secondOk) begin
          secondTag = TAG_W'(i);
          secondOk  = 1'b1;
        end
      end
    end
  end

  assign reqA       = map_en_A && (map_addr_A != '0);
  assign reqB       = map_en_B && (map_addr_B != '0);
  assign reqCnt     = (TAG_W+1)'(reqA) + (TAG_W+1)'(reqB);
  assign map_stall  = reqCnt > freeCount;
  assign map_tag_A  = firstTag;
  assign map_tag_B  = reqA ? secondTag : firstTag;
  assign grantA     = reqA && !map_stall && !flush;
  assign grantB     = reqB && !map_stall && !flush;
  assign free_count = freeCount;

  // Retire first so a flush still keeps committed results; maps follow commits so a new mapping wins
  always_comb begin
    arfValNxt   = arfVal;
    arfTagNxt   = arfTag;
    arfBusyNxt  = arfBusy;
    rrfValNxt   = rrfVal;
    rrfDestNxt  = rrfDest;
    rrfBusyNxt  = rrfBusy;
    rrfValidNxt = rrfValid;
    freeNxt     = '0;
    if (cm_en_A && rrfValid[cm_tag_A]) begin
      arfValNxt[rrfDest[cm_tag_A]] = rrfVal[cm_tag_A];
      if (arfTag[rrfDest[cm_tag_A]] == cm_tag_A) arfBusyNxt[rrfDest[cm_tag_A]] = 1'b0;
      rrfBusyNxt[cm_tag_A]  = 1'b0;
      rrfValidNxt[cm_tag_A] = 1'b0;
    end
    if (cm_en_B && rrfValid[cm_tag_B]) begin
      arfValNxt[rrfDest[cm_tag_B]] = rrfVal[cm_tag_B];
      if (arfTag[rrfDest[cm_tag_B]] == cm_tag_B) arfBusyNxt[rrfDest[cm_tag_B]] = 1'b0;
      rrfBusyNxt[cm_tag_B]  = 1'b0;
      rrfValidNxt[cm_tag_B] = 1'b0;
    end
    if (flush) begin
      arfBusyNxt  = '0;
      rrfBusyNxt  = '0;
      rrfValidNxt = '0;
    end else begin
      if (wb_en_A && rrfBusy[wb_tag_A] && rrfBusyNxt[wb_tag_A]) begin
        rrfValNxt[wb_tag_A]   = wb_data_A;
        rrfValidNxt[wb_tag_A] = 1'b1;
      end
      if (wb_en_B && rrfBusy[wb_tag_B] && rrfBusyNxt[wb_tag_B]) begin
        rrfValNxt[wb_tag_B]   = wb_data_B;
        rrfValidNxt[wb_tag_B] = 1'b1;
      end
      if (grantA) begin
        rrfBusyNxt[map_tag_A]  = 1'b1;
        rrfValidNxt[map_tag_A] = 1'b0;
        rrfDestNxt[map_tag_A]  = map_addr_A;
        arfBusyNxt[map_addr_A] = 1'b1;
        arfTagNxt[map_addr_A]  = map_tag_A;
      end
      if (grantB) begin
        rrfBusyNxt[map_tag_B]  = 1'b1;
        rrfValidNxt[map_tag_B] = 1'b0;
        rrfDestNxt[map_tag_B]  = map_addr_B;
        arfBusyNxt[map_addr_B] = 1'b1;
        arfTagNxt[map_addr_B]  = map_tag_B;
      end
    end
    for (int i = 0; i < RRF_N; i++) freeNxt = freeNxt + (TAG_W+1)'(!rrfBusyNxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARF_N; i++) begin
        arfVal[i] <= '0;
        arfTag[i] <= '0;
      end
      for (int i = 0; i < RRF_N; i++) begin
        rrfVal[i]  <= '0;
        rrfDest[i] <= '0;
      end
      arfBusy   <= '0;
      rrfBusy   <= '0;
      rrfValid  <= '0;
      freeCount <= (TAG_W+1)'(RRF_N);
    end else begin
      arfVal    <= arfValNxt;
      arfTag    <= arfTagNxt;
      arfBusy   <= arfBusyNxt;
      rrfVal    <= rrfValNxt;
      rrfDest   <= rrfDestNxt;
      rrfBusy   <= rrfBusyNxt;
      rrfValid  <= rrfValidNxt;
      freeCount <= freeNxt;
    end
  end

  assign rdAddr[0] = rd_addr_A0;
  assign rdAddr[1] = rd_addr_A1;
  assign rdAddr[2] = rd_addr_B0;
  assign rdAddr[3] = rd_addr_B1;

  // Operand lookup: ARF, then completed RRF entry, then same-cycle writeback (B beats A)
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdData[p]  = '0;
      rdReady[p] = 1'b1;
      rdTag[p]   = '0;
      if (rdAddr[p] != '0) begin
        if (!arfBusy[rdAddr[p]]) begin
          rdData[p] = arfVal[rdAddr[p]];
        end else begin
          rdTag[p] = arfTag[rdAddr[p]];
          if (rrfValid[arfTag[rdAddr[p]]]) begin
            rdData[p] = rrfVal[arfTag[rdAddr[p]]];
          end else if (wb_en_B && (wb_tag_B == arfTag[rdAddr[p]])) begin
            rdData[p] = wb_data_B;
          end else if (wb_en_A && (wb_tag_A == arfTag[rdAddr[p]])) begin
            rdData[p] = wb_data_A;
          end else begin
            rdReady[p] = 1'b0;
          end
        end
      end
    end
  end

  assign rd_data_A0  = rdData[0];
  assign rd_data_A1  = rdData[1];
  assign rd_data_B0  = rdData[2];
  assign rd_data_B1  = rdData[3];
  assign rd_ready_A0 = rdReady[0];
  assign rd_ready_A1 = rdReady[1];
  assign rd_ready_B0 = rdReady[2];
  assign rd_ready_B1 = rdReady[3];
  assign rd_tag_A0   = rdTag[0];
  assign rd_tag_A1   = rdTag[1];
  assign rd_tag_B0   = rdTag[2];
  assign rd_tag_B1   = rdTag[3];

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: reset, rename, forwarding, stall, remap, commit and flush.
module tb_rename_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        map_en_A, map_en_B;
  logic [4:0]  map_addr_A, map_addr_B;
  logic [2:0]  map_tag_A, map_tag_B;
  logic        map_stall;
  logic [4:0]  rd_addr_A0, rd_addr_A1, rd_addr_B0, rd_addr_B1;
  logic [31:0] rd_data_A0, rd_data_A1, rd_data_B0, rd_data_B1;
  logic        rd_ready_A0, rd_ready_A1, rd_ready_B0, rd_ready_B1;
  logic [2:0]  rd_tag_A0, rd_tag_A1, rd_tag_B0, rd_tag_B1;
  logic        wb_en_A, wb_en_B;
  logic [2:0]  wb_tag_A, wb_tag_B;
  logic [31:0] wb_data_A, wb_data_B;
  logic        cm_en_A, cm_en_B;
  logic [2:0]  cm_tag_A, cm_tag_B;
  logic        flush;
  logic [3:0]  free_count;

  int nCmp = 0;
  int nFail = 0;

  rename_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .map_en_A(map_en_A), .map_en_B(map_en_B),
    .map_addr_A(map_addr_A), .map_addr_B(map_addr_B),
    .map_tag_A(map_tag_A), .map_tag_B(map_tag_B), .map_stall(map_stall),
    .rd_addr_A0(rd_addr_A0), .rd_addr_A1(rd_addr_A1),
    .rd_addr_B0(rd_addr_B0), .rd_addr_B1(rd_addr_B1),
    .rd_data_A0(rd_data_A0), .rd_data_A1(rd_data_A1),
    .rd_data_B0(rd_data_B0), .rd_data_B1(rd_data_B1),
    .rd_ready_A0(rd_ready_A0), .rd_ready_A1(rd_ready_A1),
    .rd_ready_B0(rd_ready_B0), .rd_ready_B1(rd_ready_B1),
    .rd_tag_A0(rd_tag_A0), .rd_tag_A1(rd_tag_A1),
    .rd_tag_B0(rd_tag_B0), .rd_tag_B1(rd_tag_B1),
    .wb_en_A(wb_en_A), .wb_en_B(wb_en_B),
    .wb_tag_A(wb_tag_A), .wb_tag_B(wb_tag_B),
    .wb_data_A(wb_data_A), .wb_data_B(wb_data_B),
    .cm_en_A(cm_en_A), .cm_en_B(cm_en_B),
    .cm_tag_A(cm_tag_A), .cm_tag_B(cm_tag_B),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic clearIn();
    map_en_A = 0; map_en_B = 0; map_addr_A = 0; map_addr_B = 0;
    wb_en_A = 0; wb_en_B = 0; wb_tag_A = 0; wb_tag_B = 0; wb_data_A = 0; wb_data_B = 0;
    cm_en_A = 0; cm_en_B = 0; cm_tag_A = 0; cm_tag_B = 0; flush = 0;
  endtask

  task automatic setRd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] b0, input logic [4:0] b1);
    rd_addr_A0 = a0; rd_addr_A1 = a1; rd_addr_B0 = b0; rd_addr_B1 = b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clearIn();
    #1;
  endtask

  task automatic doReset();
    clearIn();
    setRd(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #3;
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    doReset();
    setRd(5, 5, 5, 5);
    #1;
    nCmp++; if (free_count !== 4'd8) begin nFail++; $display("FAIL reset_free got %0d want 8", free_count); end
    nCmp++; if (map_stall !== 1'b0) begin nFail++; $display("FAIL reset_stall got %0b want 0", map_stall); end
    nCmp++; if ({rd_ready_A0, rd_ready_A1, rd_ready_B0, rd_ready_B1} !== 4'b1111) begin nFail++;
      $display("FAIL reset_ready got %b want 1111", {rd_ready_A0, rd_ready_A1, rd_ready_B0, rd_ready_B1}); end
    nCmp++; if ((rd_data_A0 | rd_data_A1 | rd_data_B0 | rd_data_B1) !== 32'h0) begin nFail++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0", rd_data_A0, rd_data_A1, rd_data_B0, rd_data_B1); end
    map_en_A = 1; map_addr_A = 5;
    #1;
    nCmp++; if (map_tag_A !== 3'd0) begin nFail++; $display("FAIL reset_firsttag got %0d want 0", map_tag_A); end
    cycle();
    wb_en_A = 1; wb_tag_A = 0; wb_data_A = 32'h1234;
    cycle();
    cm_en_A = 1; cm_tag_A = 0;
    cycle();
    nCmp++; if (rd_data_A0 !== 32'h1234 || rd_ready_B1 !== 1'b1) begin nFail++;
      $display("FAIL commit_x5 got %h ready %b want 1234 ready 1", rd_data_A0, rd_ready_B1); end
    nCmp++; if (free_count !== 4'd8) begin nFail++; $display("FAIL commit_free got %0d want 8", free_count); end
  endtask

  task automatic test_map_forward();
    doReset();
    map_en_A = 1; map_addr_A = 3; map_en_B = 1; map_addr_B = 4;
    #1;
    nCmp++; if (map_tag_A !== 3'd0 || map_tag_B !== 3'd1) begin nFail++;
      $display("FAIL map_tags got %0d,%0d want 0,1", map_tag_A, map_tag_B); end
    cycle();
    nCmp++; if (free_count !== 4'd6) begin nFail++; $display("FAIL map_free got %0d want 6", free_count); end
    setRd(3, 4, 0, 0);
    #1;
    nCmp++; if (rd_ready_A0 !== 1'b0 || rd_tag_A0 !== 3'd0) begin nFail++;
      $display("FAIL busy_x3 got ready %b tag %0d want ready 0 tag 0", rd_ready_A0, rd_tag_A0); end
    nCmp++; if (rd_ready_A1 !== 1'b0 || rd_tag_A1 !== 3'd1) begin nFail++;
      $display("FAIL busy_x4 got ready %b tag %0d want ready 0 tag 1", rd_ready_A1, rd_tag_A1); end
    wb_en_A = 1; wb_tag_A = 0; wb_data_A = 32'hAA;
    #1;
    nCmp++; if (rd_ready_A0 !== 1'b1 || rd_data_A0 !== 32'hAA) begin nFail++;
      $display("FAIL fwd_x3 got ready %b data %h want ready 1 data aa", rd_ready_A0, rd_data_A0); end
    cycle();
    nCmp++; if (rd_ready_A0 !== 1'b1 || rd_data_A0 !== 32'hAA) begin nFail++;
      $display("FAIL rrf_x3 got ready %b data %h want ready 1 data aa", rd_ready_A0, rd_data_A0); end
    // both writebacks hit x4's tag: B must win
    wb_en_A = 1; wb_tag_A = 1; wb_data_A = 32'h1; wb_en_B = 1; wb_tag_B = 1; wb_data_B = 32'h2;
    #1;
    nCmp++; if (rd_data_A1 !== 32'h2 || rd_ready_A1 !== 1'b1) begin nFail++;
      $display("FAIL fwd_prio got ready %b data %h want ready 1 data 2", rd_ready_A1, rd_data_A1); end
    cycle();
  endtask

  task automatic test_stall();
    doReset();
    for (int i = 0; i < 7; i++) begin
      map_en_A = 1; map_addr_A = 5'(i + 1);
      cycle();
    end
    nCmp++; if (free_count !== 4'd1) begin nFail++; $display("FAIL fill_free got %0d want 1", free_count); end
    map_en_A = 1; map_addr_A = 10; map_en_B = 1; map_addr_B = 11;
    #1;
    nCmp++; if (map_stall !== 1'b1) begin nFail++; $display("FAIL stall_two got %b want 1", map_stall); end
    cycle();
    setRd(10, 11, 0, 0);
    #1;
    nCmp++; if (free_count !== 4'd1 || rd_ready_A0 !== 1'b1 || rd_ready_A1 !== 1'b1) begin nFail++;
      $display("FAIL stall_nochange got free %0d ready %b%b want free 1 ready 11", free_count, rd_ready_A0, rd_ready_A1); end
    map_en_A = 1; map_addr_A = 10;
    #1;
    nCmp++; if (map_stall !== 1'b0 || map_tag_A !== 3'd7) begin nFail++;
      $display("FAIL last_grant got stall %b tag %0d want stall 0 tag 7", map_stall, map_tag_A); end
    cycle();
    nCmp++; if (free_count !== 4'd0) begin nFail++; $display("FAIL empty_free got %0d want 0", free_count); end
    map_en_B = 1; map_addr_B = 11;
    #1;
    nCmp++; if (map_stall !== 1'b1) begin nFail++; $display("FAIL stall_bonly got %b want 1", map_stall); end
    cycle();
  endtask

  task automatic test_remap();
    doReset();
    map_en_A = 1; map_addr_A = 7;
    cycle();
    map_en_A = 1; map_addr_A = 7;
    #1;
    nCmp++; if (map_tag_A !== 3'd1) begin nFail++; $display("FAIL remap_tag got %0d want 1", map_tag_A); end
    cycle();
    setRd(7, 0, 0, 0);
    #1;
    nCmp++; if (rd_ready_A0 !== 1'b0 || rd_tag_A0 !== 3'd1) begin nFail++;
      $display("FAIL remap_read got ready %b tag %0d want ready 0 tag 1", rd_ready_A0, rd_tag_A0); end
    wb_en_A = 1; wb_tag_A = 0; wb_data_A = 32'h10;
    cycle();
    cm_en_A = 1; cm_tag_A = 0;
    cycle();
    nCmp++; if (rd_ready_A0 !== 1'b0 || rd_tag_A0 !== 3'd1 || free_count !== 4'd7) begin nFail++;
      $display("FAIL old_commit got ready %b tag %0d free %0d want ready 0 tag 1 free 7", rd_ready_A0, rd_tag_A0, free_count); end
    wb_en_A = 1; wb_tag_A = 1; wb_data_A = 32'h20;
    cycle();
    cm_en_A = 1; cm_tag_A = 1;
    cycle();
    nCmp++; if (rd_ready_A0 !== 1'b1 || rd_data_A0 !== 32'h20 || free_count !== 4'd8) begin nFail++;
      $display("FAIL new_commit got ready %b data %h free %0d want ready 1 data 20 free 8", rd_ready_A0, rd_data_A0, free_count); end
  endtask

  task automatic test_same_reg();
    doReset();
    map_en_A = 1; map_addr_A = 9; map_en_B = 1; map_addr_B = 9;
    cycle();
    setRd(9, 0, 0, 0);
    #1;
    nCmp++; if (rd_tag_A0 !== 3'd1 || rd_ready_A0 !== 1'b0 || free_count !== 4'd6) begin nFail++;
      $display("FAIL same_reg got tag %0d ready %b free %0d want tag 1 ready 0 free 6", rd_tag_A0, rd_ready_A0, free_count); end
    map_en_A = 1; map_addr_A = 0;
    cycle();
    nCmp++; if (free_count !== 4'd6) begin nFail++; $display("FAIL map_x0 got free %0d want 6", free_count); end
    map_en_A = 1; map_addr_A = 0; map_en_B = 1; map_addr_B = 12;
    #1;
    nCmp++; if (map_tag_B !== 3'd2 || map_stall !== 1'b0) begin nFail++;
      $display("FAIL x0_bonly got tag %0d stall %b want tag 2 stall 0", map_tag_B, map_stall); end
    cycle();
    nCmp++; if (free_count !== 4'd5) begin nFail++; $display("FAIL x0_bonly_free got %0d want 5", free_count); end
  endtask

  task automatic test_back_to_back();
    doReset();
    map_en_A = 1; map_addr_A = 6; map_en_B = 1; map_addr_B = 6;
    cycle();
    wb_en_A = 1; wb_tag_A = 0; wb_data_A = 32'h11; wb_en_B = 1; wb_tag_B = 1; wb_data_B = 32'h22;
    cycle();
    cm_en_A = 1; cm_tag_A = 0; cm_en_B = 1; cm_tag_B = 1;
    cycle();
    setRd(0, 0, 6, 0);
    #1;
    nCmp++; if (rd_data_B0 !== 32'h22 || rd_ready_B0 !== 1'b1 || free_count !== 4'd8) begin nFail++;
      $display("FAIL dual_commit got data %h ready %b free %0d want data 22 ready 1 free 8", rd_data_B0, rd_ready_B0, free_count); end
  endtask

  task automatic test_flush();
    doReset();
    map_en_A = 1; map_addr_A = 1; map_en_B = 1; map_addr_B = 2;
    cycle();
    map_en_A = 1; map_addr_A = 3;
    cycle();
    wb_en_A = 1; wb_tag_A = 0; wb_data_A = 32'h55;
    cycle();
    flush = 1; cm_en_A = 1; cm_tag_A = 0; map_en_A = 1; map_addr_A = 4;
    #1;
    nCmp++; if (map_stall !== 1'b0) begin nFail++; $display("FAIL flush_stall got %b want 0", map_stall); end
    cycle();
    setRd(1, 2, 3, 4);
    #1;
    nCmp++; if (free_count !== 4'd8) begin nFail++; $display("FAIL flush_free got %0d want 8", free_count); end
    nCmp++; if (rd_data_A0 !== 32'h55 || rd_ready_A0 !== 1'b1) begin nFail++;
      $display("FAIL flush_commit got data %h ready %b want data 55 ready 1", rd_data_A0, rd_ready_A0); end
    nCmp++; if ({rd_ready_A1, rd_ready_B0, rd_ready_B1} !== 3'b111 || (rd_data_A1 | rd_data_B0 | rd_data_B1) !== 32'h0) begin nFail++;
      $display("FAIL flush_ready got %b data %h/%h/%h want 111 data 0", {rd_ready_A1, rd_ready_B0, rd_ready_B1}, rd_data_A1, rd_data_B0, rd_data_B1); end
    map_en_A = 1; map_addr_A = 5;
    #1;
    nCmp++; if (map_tag_A !== 3'd0) begin nFail++; $display("FAIL post_flush_tag got %0d want 0", map_tag_A); end
    cycle();
  endtask

  initial begin
    rst_n = 1;
    clearIn();
    setRd(0, 0, 0, 0);
    test_reset();
    test_map_forward();
    test_stall();
    test_remap();
    test_same_reg();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
